// File: rtl/leaf_stream_fifo_if.sv
// Stream bundle for one leaf FIFO: producer side (in_*) and consumer side (out_*).
// A word moves on a rising edge where valid and ready are both 1; valid never waits on ready.
interface leaf_stream_fifo_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/leaf_stream_fifo.sv
// First-word-fall-through valid/ready FIFO with occupancy, synchronous flush and
// a wrapping count of output handshakes.
module leaf_stream_fifo #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  parameter  int CNT_W  = 16,
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  leaf_stream_fifo_if.slave bus,
  output logic [LVL_W-1:0] level,
  output logic [CNT_W-1:0] xfer_cnt
);
  localparam int               AW       = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic              push;
  logic              pop;

  // Handshake outputs come only from registered state, so no ready->valid path exists.
  assign bus.in_ready  = (level != FULL_LVL);
  assign bus.out_valid = (level != '0);
  assign bus.out_data  = mem[rd_ptr];

  assign push = bus.in_valid  & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  // Storage is intentionally not reset; it is only observable while out_valid is high.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && push) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      xfer_cnt <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        xfer_cnt <= xfer_cnt + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

// File: tb/tb_leaf_stream_fifo.sv
// Bench for leaf_stream_fifo: directed vector table, corner sequences, random traffic
// against a queue model, and a narrow-counter instance for wrap-around.
module tb_leaf_stream_fifo;
  localparam int DEPTH = 4;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic [LVL_W-1:0] level, level2;
  logic [15:0] xfer_cnt;
  logic [3:0]  xfer_cnt2;

  leaf_stream_fifo_if #(.DATA_W(8)) bus ();
  leaf_stream_fifo_if #(.DATA_W(8)) bus2 ();

  leaf_stream_fifo #(.DATA_W(8), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus.slave),
    .level(level), .xfer_cnt(xfer_cnt)
  );

  leaf_stream_fifo #(.DATA_W(8), .DEPTH(DEPTH), .CNT_W(4)) dut_w4 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .bus(bus2.slave),
    .level(level2), .xfer_cnt(xfer_cnt2)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  int cnt_m = 0;

  typedef struct {
    logic       rst_n;
    logic       flush;
    logic       iv;
    logic [7:0] din;
    logic       ordy;
    int         e_level;
    logic       e_ov;
    logic       e_ir;
    logic [7:0] e_od;
    int         e_cnt;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".level"}, 32'(level), 32'(exp_q.size()));
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(exp_q.size() != 0));
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(exp_q.size() != DEPTH));
    chk({tag, ".xfer_cnt"}, 32'(xfer_cnt), 32'(cnt_m & 16'hFFFF));
    if (exp_q.size() != 0) chk({tag, ".out_data"}, 32'(bus.out_data), 32'(exp_q[0]));
  endtask

  task automatic drive(input logic iv, input logic [7:0] din, input logic ordy);
    bus.in_valid  = iv;
    bus.in_data   = din;
    bus.out_ready = ordy;
  endtask

  // One clock: model update from pre-edge inputs, then compare #1 after the edge.
  task automatic step(input string tag);
    bit         push_m, pop_m;
    logic [7:0] din_m;
    push_m = bus.in_valid && (exp_q.size() < DEPTH);
    pop_m  = bus.out_ready && (exp_q.size() > 0);
    din_m  = bus.in_data;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      exp_q.delete();
      cnt_m = 0;
    end else if (flush) begin
      exp_q.delete();
    end else begin
      if (pop_m) begin
        void'(exp_q.pop_front());
        cnt_m++;
      end
      if (push_m) exp_q.push_back(din_m);
    end
    check_model(tag);
  endtask

  initial begin
    int saved_cnt;
    int lvl2_m, cnt2_m;
    logic [3:0] prev2;
    bit saw_wrap;

    //                 rst flush iv din    ordy lvl ov    ir    od     cnt
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1, 1'b1, 1'b1, 8'h11, 0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 2, 1'b1, 1'b1, 8'h11, 0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 8'h33, 1'b0, 3, 1'b1, 1'b1, 8'h11, 0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 8'h44, 1'b0, 4, 1'b1, 1'b0, 8'h11, 0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 4, 1'b1, 1'b0, 8'h11, 0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 3, 1'b1, 1'b1, 8'h22, 1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 2, 1'b1, 1'b1, 8'h33, 2};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1, 1'b1, 1'b1, 8'h44, 3};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 0, 1'b0, 1'b1, 8'h00, 4};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 0, 1'b0, 1'b1, 8'h00, 4};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 8'h66, 1'b1, 1, 1'b1, 1'b1, 8'h66, 4};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 8'h77, 1'b0, 2, 1'b1, 1'b1, 8'h66, 4};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2, 1'b1, 1'b1, 8'h66, 4};

    bus2.in_valid = 1'b0;
    bus2.in_data  = '0;
    bus2.out_ready = 1'b0;

    // Reset held three cycles with a producer pushing.
    rst_n = 1'b0;
    drive(1'b1, 8'hEE, 1'b0);
    for (int i = 0; i < 3; i++) step("reset");
    chk("reset.level", 32'(level), 32'd0);
    chk("reset.out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset.in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset.xfer_cnt", 32'(xfer_cnt), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      rst_n = tbl[i].rst_n;
      flush = tbl[i].flush;
      drive(tbl[i].iv, tbl[i].din, tbl[i].ordy);
      step($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.level", i), 32'(level), 32'(tbl[i].e_level));
      chk($sformatf("tbl%0d.out_valid", i), 32'(bus.out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("tbl%0d.in_ready", i), 32'(bus.in_ready), 32'(tbl[i].e_ir));
      chk($sformatf("tbl%0d.xfer_cnt", i), 32'(xfer_cnt), 32'(tbl[i].e_cnt));
      if (tbl[i].e_ov) chk($sformatf("tbl%0d.out_data", i), 32'(bus.out_data), 32'(tbl[i].e_od));
    end

    // Streaming at level 2: pointers wrap several times.
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 8'(8'h80 + k), 1'b1);
      step("stream");
      chk("stream.level", 32'(level), 32'd2);
    end

    // Fill, then offer push+pop while full: only the pop happens.
    drive(1'b1, 8'hC1, 1'b0); step("fill");
    drive(1'b1, 8'hC2, 1'b0); step("fill");
    chk("full.in_ready", 32'(bus.in_ready), 32'd0);
    drive(1'b1, 8'hC3, 1'b1); step("full_pop");
    chk("full_pop.level", 32'(level), 32'd3);
    chk("full_pop.in_ready", 32'(bus.in_ready), 32'd1);

    // Flush at level 3 with push and pop offered.
    saved_cnt = cnt_m;
    flush = 1'b1;
    drive(1'b1, 8'hD1, 1'b1); step("flush");
    flush = 1'b0;
    chk("flush.level", 32'(level), 32'd0);
    chk("flush.out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush.xfer_cnt", 32'(xfer_cnt), 32'(saved_cnt));

    // Flush and reset together: reset wins and clears the counter.
    drive(1'b1, 8'hD2, 1'b0); step("pre_rst");
    drive(1'b1, 8'hD3, 1'b1); step("pre_rst");
    flush = 1'b1;
    rst_n = 1'b0;
    drive(1'b1, 8'hD4, 1'b1); step("flush_rst");
    chk("flush_rst.xfer_cnt", 32'(xfer_cnt), 32'd0);
    chk("flush_rst.level", 32'(level), 32'd0);
    flush = 1'b0;
    rst_n = 1'b1;

    // Random 50/50 valid/ready traffic against the queue model.
    for (int k = 0; k < 10000; k++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
      step("rand");
    end
    drive(1'b0, 8'h00, 1'b0);

    // Narrow counter instance: continuous traffic must wrap 15 -> 0.
    lvl2_m = 0;
    cnt2_m = 0;
    saw_wrap = 1'b0;
    prev2 = xfer_cnt2;
    chk("w4.start_cnt", 32'(xfer_cnt2), 32'd0);
    bus2.in_valid = 1'b1;
    bus2.out_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      bus2.in_data = 8'($urandom);
      if (lvl2_m > 0) cnt2_m++;
      else lvl2_m = 1;
      @(posedge clk);
      #1;
      chk("w4.xfer_cnt", 32'(xfer_cnt2), 32'(cnt2_m % 16));
      chk("w4.level", 32'(level2), 32'(lvl2_m));
      if (prev2 == 4'hF && xfer_cnt2 == 4'h0) saw_wrap = 1'b1;
      prev2 = xfer_cnt2;
    end
    chk("w4.wrap_seen", 32'(saw_wrap), 32'd1);
    bus2.in_valid = 1'b0;
    bus2.out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
